lsu_byte_ctrl: RTL and testbench
================================

Name: lsu_byte_ctrl

Overview:
- Load/store initiator between the ARMv8 datapath MEM stage and the byte-wide data memory / MMIO port.
- Accepts one 1/2/4/8-byte LDUR/STUR-class request at a time over a valid/ready handshake.
- Serializes the request into single-byte memory reads/writes, lowest address first, and returns a little-endian, optionally sign-extended 64-bit result.
- Decodes the region field addr[17:16]: 0 = RAM, 1 = LED register, 2 = switches, 3 = illegal.

Parameters:
- MEM_SIZE, 100, RAM size in bytes; region-0 accesses must satisfy addr+N <= MEM_SIZE.
- ADDR_W, 64, request and memory address width.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  1  request present; must be held stable until accepted.
- o_req_ready  out  1  high only in IDLE.
- i_req_wr  in  1  1 = store, 0 = load.
- i_req_size  in  2  0/1/2/3 = 1/2/4/8 bytes (N).
- i_req_signed  in  1  load only: sign-extend from bit 8N-1.
- i_req_addr  in  ADDR_W  byte address.
- i_req_wdata  in  64  store data; byte k = bits [8k+7:8k].
- o_rsp_valid  out  1  one-cycle completion pulse (loads and stores).
- o_rsp_rdata  out  64  load result; 0 for stores and errors.
- o_rsp_err  out  1  valid with o_rsp_valid; misaligned, out of range, or illegal region.
- o_mem_addr  out  ADDR_W  byte address to memory.
- o_mem_wdata  out  8  write byte.
- o_mem_rd  out  1  byte read strobe.
- o_mem_wr  out  1  byte write strobe.
- i_mem_rdata  in  8  read byte; combinational from o_mem_addr in the same cycle.

Behaviour:
- Reset (async, i_rst_n=0):
  - State = IDLE, internal registers cleared.
  - Outputs: o_req_ready=1, o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, o_mem_addr=0, o_mem_wdata=0, o_mem_rd=0, o_mem_wr=0.
  - Reset mid-transfer drops strobes immediately; the transaction is lost and produces no response.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On i_req_valid & o_req_ready, latch the request and run the checks below.
  - Any check failing -> RESP with err=1; no memory strobe is ever asserted.
  - Otherwise -> ACCESS with byte counter k=0.
- Error checks:
  - Misaligned: addr mod N != 0.
  - Region 0: addr+N > MEM_SIZE, computed without 64-bit overflow wrap (overflow counts as out of range).
  - Region 1 or 2 with size != 0.
  - Region 3.
  - Store to region 2 (switches are read-only).
- ACCESS (one byte per cycle):
  - o_mem_addr = base+k; o_mem_rd = ~wr; o_mem_wr = wr; o_mem_wdata = wdata byte k.
  - Load: on the rising edge ending the cycle, capture i_mem_rdata into result byte k.
  - After byte N-1 -> RESP. ACCESS lasts exactly N cycles; MMIO always lasts 1 cycle.
- RESP:
  - o_rsp_valid=1 for exactly one cycle, then -> IDLE. Strobes are low.
  - Load result: bytes 0..N-1 assembled little-endian; upper bits zero-filled, or copies of bit 8N-1 when signed.
  - i_req_signed is ignored for stores.
- Latency and throughput:
  - Acceptance edge E. Strobes active cycles E+1..E+N. o_rsp_valid high in cycle E+N+1.
  - Next acceptance is possible at edge E+N+2 at the earliest.
  - Error requests: o_rsp_valid in cycle E+1.
- o_req_ready=0 in ACCESS and RESP; i_req_* are ignored while busy.
- There is no response backpressure; the consumer must take the pulse.
- o_mem_addr / o_mem_wdata = 0 whenever no strobe is active.

Test Plan:
- Store then load doubleword: STUR addr=8, wdata=0x1122334455667788 -> o_mem_wr for 8 cycles, addresses 8..15, bytes 0x88 first through 0x11 last. Then LDUR addr=8 -> rdata=0x1122334455667788, err=0, o_rsp_valid exactly 10 cycles after the store response.
- Signed vs unsigned byte load: memory[20]=0xF0. size=0, signed=1 -> 0xFFFFFFFFFFFFFFF0; signed=0 -> 0x00000000000000F0. Signed halfword at addr 20 with [21]=0x7F -> 0x0000000000007FF0.
- Errors:
  - Word load at addr=6 -> misaligned.
  - Doubleword at addr=96 with MEM_SIZE=100 -> out of range.
  - addr=0x30000 -> region 3.
  - Each gives err=1 and rdata=0 one cycle after acceptance, with zero strobe cycles.
- MMIO:
  - Byte store to 0x10000 with wdata=0xA5 -> one o_mem_wr cycle at 0x10000, data 0xA5.
  - Signed byte load at 0x20000 with switches returning 0x81 -> 0xFFFFFFFFFFFFFF81.
  - Halfword to 0x10000 -> err.
  - Byte store to 0x20000 -> err.
- Busy handling: assert a second valid request during ACCESS -> o_req_ready=0 and it is not taken; it is accepted on the first IDLE cycle after the RESP pulse.
- Reset mid-operation: deassert i_rst_n during byte 3 of a doubleword store -> o_mem_wr drops to 0 asynchronously; after release, state is IDLE and no o_rsp_valid is ever produced for that request.

Source files
------------

// File: rtl/lsu_byte_ctrl_if.sv
// lsu_byte_ctrl_if: request/response and byte-memory signals of the load/store initiator
interface lsu_byte_ctrl_if #(parameter int ADDR_W = 64);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_wr;
  logic [1:0]        i_req_size;
  logic              i_req_signed;
  logic [ADDR_W-1:0] i_req_addr;
  logic [63:0]       i_req_wdata;
  logic              o_rsp_valid;
  logic [63:0]       o_rsp_rdata;
  logic              o_rsp_err;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        o_mem_wdata;
  logic              o_mem_rd;
  logic              o_mem_wr;
  logic [7:0]        i_mem_rdata;
  modport master (
    output i_req_valid, i_req_wr, i_req_size, i_req_signed, i_req_addr, i_req_wdata, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_addr, o_mem_wdata, o_mem_rd, o_mem_wr
  );
  modport slave (
    input  i_req_valid, i_req_wr, i_req_size, i_req_signed, i_req_addr, i_req_wdata, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_addr, o_mem_wdata, o_mem_rd, o_mem_wr
  );
endinterface

// File: rtl/lsu_byte_ctrl.sv
// lsu_byte_ctrl: serializes 1/2/4/8-byte loads/stores into byte accesses, little-endian,
// with alignment/range/region checks and optional sign extension of load results.
module lsu_byte_ctrl #(
  parameter int MEM_SIZE = 100,
  parameter int ADDR_W   = 64
) (
  input logic          i_clk,
  input logic          i_rst_n,
  lsu_byte_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic              wr_q, signed_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q, rdata_q;
  logic [2:0]        k_q;
  logic [3:0]        n_req;
  logic [1:0]        region;
  logic [ADDR_W:0]   end_addr;
  logic              misal, req_err, accept, active, resp;
  logic [2:0]        k_last;
  logic              sbit;
  logic [63:0]       mask, ext;
  assign n_req  = 4'd1 << bus.i_req_size;
  assign region = bus.i_req_addr[17:16];
  // one extra bit so that addr+N near the top of the address space cannot wrap back into range
  assign end_addr = {1'b0, bus.i_req_addr} + (ADDR_W+1)'(n_req);
  assign misal    = |(bus.i_req_addr[2:0] & (n_req[2:0] - 3'd1));
  assign req_err  = misal
                  | ((region == 2'd0) & (end_addr > (ADDR_W+1)'(MEM_SIZE)))
                  | ((region != 2'd0) & (bus.i_req_size != 2'd0))
                  | (region == 2'd3)
                  | ((region == 2'd2) & bus.i_req_wr);
  assign accept = bus.i_req_valid & (state_q == IDLE);
  assign active = state_q == ACCESS;
  assign resp   = state_q == RESP;
  assign k_last = 3'((4'd1 << size_q) - 4'd1);
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE)   ? (accept ? (req_err ? RESP : ACCESS) : IDLE) :
              (state_q == ACCESS) ? ((k_q == k_last) ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      k_q      <= 3'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q     <= bus.i_req_wr;
        signed_q <= bus.i_req_signed;
        err_q    <= req_err;
        size_q   <= bus.i_req_size;
        addr_q   <= bus.i_req_addr;
        wdata_q  <= bus.i_req_wdata;
        rdata_q  <= '0;
        k_q      <= 3'd0;
      end else if (active) begin
        k_q <= k_q + 3'd1;
        if (!wr_q) rdata_q[{k_q, 3'b000} +: 8] <= bus.i_mem_rdata;
      end
    end
  end
  // result bytes above N are still zero from acceptance, so only the sign fill is OR-ed in
  assign sbit = rdata_q[6'((7'd8 << size_q) - 7'd1)];
  assign mask = (size_q == 2'd3) ? '1 : (64'd1 << (7'd8 << size_q)) - 64'd1;
  assign ext  = rdata_q | ((signed_q & sbit) ? ~mask : 64'd0);
  always_comb begin
    bus.o_req_ready = state_q == IDLE;
    bus.o_mem_rd    = active & ~wr_q;
    bus.o_mem_wr    = active & wr_q;
    bus.o_mem_addr  = active ? addr_q + ADDR_W'(k_q) : '0;
    bus.o_mem_wdata = active ? wdata_q[{k_q, 3'b000} +: 8] : 8'h00;
    bus.o_rsp_valid = resp;
    bus.o_rsp_err   = resp & err_q;
    bus.o_rsp_rdata = (resp & ~wr_q & ~err_q) ? ext : 64'd0;
  end
endmodule

// File: tb/tb_lsu_byte_ctrl.sv
// tb_lsu_byte_ctrl: transaction-level model predicts every output cycle; directed vectors
// plus literal checks of responses, memory contents and mid-transfer reset.
module tb_lsu_byte_ctrl;
  localparam int MEM_SIZE = 100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  lsu_byte_ctrl_if #(.ADDR_W(64)) bus();
  lsu_byte_ctrl #(.MEM_SIZE(MEM_SIZE), .ADDR_W(64)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  logic [7:0] ram [0:255] = '{default: 8'h00};
  logic [7:0] led = 8'h00;
  logic [7:0] sw  = 8'h81;
  assign bus.i_mem_rdata = (bus.o_mem_addr[17:16] == 2'd2) ? sw :
                           (bus.o_mem_addr[17:16] == 2'd1) ? led :
                           (bus.o_mem_addr < 64'd100) ? ram[bus.o_mem_addr[7:0]] : 8'h00;
  always @(posedge clk)
    if (bus.o_mem_wr) begin
      if (bus.o_mem_addr[17:16] == 2'd1) led <= bus.o_mem_wdata;
      else if (bus.o_mem_addr < 64'd100) ram[bus.o_mem_addr[7:0]] <= bus.o_mem_wdata;
    end
  typedef struct packed {
    logic rd; logic wr; logic [63:0] addr; logic [7:0] wdata;
    logic rsp; logic err; logic [63:0] rdata;
  } exp_t;
  typedef struct {logic [63:0] rdata; logic err; int cyc;} rsp_t;
  exp_t q[$];
  rsp_t log_q[$];
  logic [7:0] mdl [0:99] = '{default: 8'h00};
  logic [7:0] mdl_led = 8'h00;
  int total = 0, bad = 0, cyc = 0;
  bit exp_idle = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    rsp_t r;
    cyc++;
    exp_idle = (q.size() == 0);
    e = exp_idle ? '0 : q.pop_front();
    total++;
    if ({bus.o_req_ready, bus.o_mem_rd, bus.o_mem_wr, bus.o_mem_addr, bus.o_mem_wdata,
         bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_rdata} !==
        {exp_idle, e.rd, e.wr, e.addr, e.wdata, e.rsp, e.err, e.rdata}) begin
      bad++;
      $display("FAIL cycle%0d: got rdy=%b rd=%b wr=%b a=%h wd=%h v=%b err=%b rd=%h required rdy=%b rd=%b wr=%b a=%h wd=%h v=%b err=%b rd=%h",
               cyc, bus.o_req_ready, bus.o_mem_rd, bus.o_mem_wr, bus.o_mem_addr, bus.o_mem_wdata,
               bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_rdata,
               exp_idle, e.rd, e.wr, e.addr, e.wdata, e.rsp, e.err, e.rdata);
    end
    if (bus.o_rsp_valid) begin
      r.rdata = bus.o_rsp_rdata;
      r.err   = bus.o_rsp_err;
      r.cyc   = cyc;
      log_q.push_back(r);
    end
  end
  task automatic model(input bit wr, input int size, input bit sgn, input logic [63:0] a, input logic [63:0] wd);
    int n, rg;
    bit err;
    exp_t e;
    logic [63:0] v;
    logic [7:0] b;
    n  = 1 << size;
    rg = int'(a[17:16]);
    v  = 64'd0;
    err = (a % n != 0) || rg == 3 || (rg != 0 && size != 0) || (rg == 2 && wr) ||
          (rg == 0 && a > 64'(MEM_SIZE - n));
    if (!err)
      for (int k = 0; k < n; k++) begin
        e = '0;
        e.rd = !wr; e.wr = wr; e.addr = a + 64'(k); e.wdata = wd[8*k +: 8];
        q.push_back(e);
        if (wr) begin
          if (rg == 1) mdl_led = wd[8*k +: 8];
          else mdl[int'(a) + k] = wd[8*k +: 8];
        end else begin
          b = (rg == 2) ? sw : (rg == 1) ? mdl_led : mdl[int'(a) + k];
          v = v | (64'(b) << (8 * k));
        end
      end
    if (!wr && sgn && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    e = '0;
    e.rsp = 1'b1; e.err = err; e.rdata = (wr || err) ? 64'd0 : v;
    q.push_back(e);
  endtask
  task automatic issue(input bit wr, input int size, input bit sgn, input logic [63:0] a, input logic [63:0] wd);
    int t = 0;
    bus.i_req_wr = wr; bus.i_req_size = 2'(size); bus.i_req_signed = sgn;
    bus.i_req_addr = a; bus.i_req_wdata = wd; bus.i_req_valid = 1'b1;
    do begin @(posedge clk); t++; end while (!exp_idle && t < 100);
    if (!exp_idle) begin total++; bad++; $display("FAIL accept_timeout: got busy required idle within 100"); end
    #1 bus.i_req_valid = 1'b0;
    model(wr, size, sgn, a, wd);
  endtask
  task automatic wait_done();
    int t = 0;
    do begin @(negedge clk); #1; t++; end while (!(q.size() == 0 && exp_idle) && t < 200);
    if (!(q.size() == 0 && exp_idle)) begin total++; bad++; $display("FAIL done_timeout: got pending=%0d required 0", q.size()); end
  endtask
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s: got %h required %h", nm, got, exp); end
  endtask
  initial begin
    #200000 $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, nlog;
    bus.i_req_valid = 1'b0; bus.i_req_wr = 1'b0; bus.i_req_size = 2'd0; bus.i_req_signed = 1'b0;
    bus.i_req_addr = '0; bus.i_req_wdata = '0;
    #2;
    chk("rst_ready", bus.o_req_ready, 1);
    chk("rst_rsp", {bus.o_rsp_valid, bus.o_rsp_err}, 0);
    chk("rst_rdata", bus.o_rsp_rdata, 0);
    chk("rst_mem", {bus.o_mem_rd, bus.o_mem_wr, bus.o_mem_addr, bus.o_mem_wdata}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // store doubleword then load back; load held valid while store is busy
    issue(1, 3, 0, 64'd8, 64'h1122334455667788);
    issue(0, 3, 0, 64'd8, 64'd0);
    wait_done();
    n = log_q.size();
    chk("st_dw_err", log_q[n-2].err, 0);
    chk("ld_dw", log_q[n-1].rdata, 64'h1122334455667788);
    chk("ld_gap", 64'(log_q[n-1].cyc - log_q[n-2].cyc), 10);
    chk("ram8", ram[8], 8'h88);
    chk("ram15", ram[15], 8'h11);
    // signed vs unsigned
    issue(1, 0, 0, 64'd20, 64'hF0);
    issue(1, 0, 0, 64'd21, 64'h7F);
    issue(0, 0, 1, 64'd20, 64'd0);
    issue(0, 0, 0, 64'd20, 64'd0);
    issue(0, 1, 1, 64'd20, 64'd0);
    wait_done();
    n = log_q.size();
    chk("ld_b_s", log_q[n-3].rdata, 64'hFFFFFFFFFFFFFFF0);
    chk("ld_b_u", log_q[n-2].rdata, 64'h00000000000000F0);
    chk("ld_h_s", log_q[n-1].rdata, 64'h0000000000007FF0);
    // last legal word before MEM_SIZE, signed word
    issue(1, 2, 0, 64'd96, 64'hDEADBEEF);
    issue(0, 2, 1, 64'd96, 64'd0);
    wait_done();
    n = log_q.size();
    chk("ld_w96_err", log_q[n-1].err, 0);
    chk("ld_w96", log_q[n-1].rdata, 64'hFFFFFFFFDEADBEEF);
    // error requests
    issue(0, 2, 0, 64'd6, 64'd0);
    issue(0, 3, 0, 64'd96, 64'd0);
    issue(0, 0, 0, 64'h30000, 64'd0);
    issue(0, 3, 0, 64'hFFFF_FFFF_FFFC_FFF8, 64'd0);
    issue(1, 1, 0, 64'h10000, 64'd0);
    issue(1, 0, 0, 64'h20000, 64'hA5);
    wait_done();
    n = log_q.size();
    for (int i = 1; i <= 6; i++) chk($sformatf("err_%0d", i), {log_q[n-i].err, log_q[n-i].rdata}, {1'b1, 64'd0});
    // MMIO
    issue(1, 0, 0, 64'h10000, 64'hA5);
    issue(0, 0, 1, 64'h20000, 64'd0);
    issue(0, 0, 0, 64'h10000, 64'd0);
    wait_done();
    n = log_q.size();
    chk("led", led, 8'hA5);
    chk("sw_s", log_q[n-2].rdata, 64'hFFFFFFFFFFFFFF81);
    chk("led_rd", log_q[n-1].rdata, 64'h00000000000000A5);
    // reset during byte 3 of a doubleword store
    nlog = log_q.size();
    issue(1, 3, 0, 64'd48, 64'h0102030405060708);
    repeat (3) @(posedge clk);
    #2;
    chk("mid_byte3", {bus.o_mem_wr, bus.o_mem_addr}, {1'b1, 64'd51});
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("rst_async", {bus.o_mem_rd, bus.o_mem_wr, bus.o_mem_addr}, 0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_rsp", 64'(log_q.size()), 64'(nlog));
    chk("ram50", ram[50], 8'h06);
    chk("ram51", ram[51], 8'h00);
    issue(0, 0, 0, 64'd50, 64'd0);
    wait_done();
    chk("post_rst_ld", log_q[log_q.size()-1].rdata, 64'h06);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
